// File: rtl/min_weight_select.sv
// min_weight_select
// Consumes one packet of GF(2) candidate solutions and finds the candidate
// with the smallest Hamming weight under count_mask. That minimum is offered
// as a per-problem result over a valid/ready handshake. Every accepted result
// weight is also added into a saturating running total.
//
// Optional feature: define MIN_WEIGHT_ARGMIN_EN to also track the argmin
// candidate and expose it on result_solution.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   tvalid/tdata/tlast/tready  solution stream sink (tready is registered)
//   count_mask        tdata bits that count toward the weight
//   result_valid/result_ready  per-packet result handshake
//   result_weight     minimum masked weight of the packet
//   result_solution   tdata of the earliest minimum-weight beat (argmin build)
//   clear_total       zero the running total
//   total             saturating sum of accepted result weights
module min_weight_select #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WEIGHT_W   = $clog2(DATA_WIDTH + 1),
    parameter int unsigned TOTAL_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tvalid,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tlast,
    output logic                  tready,
    input  logic [DATA_WIDTH-1:0] count_mask,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [WEIGHT_W-1:0]   result_weight,
`ifdef MIN_WEIGHT_ARGMIN_EN
    output logic [DATA_WIDTH-1:0] result_solution,
`endif
    input  logic                  clear_total,
    output logic [TOTAL_W-1:0]    total
);

    // Sum is wide enough for either operand plus a carry out.
    localparam int unsigned SUM_W = ((TOTAL_W > WEIGHT_W) ? TOTAL_W : WEIGHT_W) + 1;

    typedef enum logic {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;

    state_t              state;
    logic                first;
    logic [WEIGHT_W-1:0] min_w;
    logic [WEIGHT_W-1:0] beat_w;
    logic [WEIGHT_W-1:0] fold_w;
    logic                take_beat;
    logic                accept;
    logic                handshake;
    logic [SUM_W-1:0]    sum;
    logic [TOTAL_W-1:0]  total_nxt;
`ifdef MIN_WEIGHT_ARGMIN_EN
    logic [DATA_WIDTH-1:0] min_x;
    logic [DATA_WIDTH-1:0] fold_x;
`endif

    // Masked popcount of the current beat.
    always_comb begin
        beat_w = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            beat_w = beat_w + WEIGHT_W'(tdata[i] & count_mask[i]);
        end
    end

    // Running minimum including the current beat; strict compare keeps the earliest tie.
    always_comb begin
        take_beat = first || (beat_w < min_w);
        fold_w    = take_beat ? beat_w : min_w;
    end

`ifdef MIN_WEIGHT_ARGMIN_EN
    always_comb fold_x = take_beat ? tdata : min_x;
`endif

    assign accept    = tvalid && tready;
    assign handshake = result_valid && result_ready;

    // Clear is applied before the handshake add; saturate at all-ones.
    always_comb begin
        sum = clear_total ? '0 : SUM_W'(total);
        if (handshake) begin
            sum = sum + SUM_W'(result_weight);
        end
        if (sum > SUM_W'({TOTAL_W{1'b1}})) begin
            total_nxt = {TOTAL_W{1'b1}};
        end else begin
            total_nxt = TOTAL_W'(sum);
        end
    end

    // Collect/result state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= COLLECT;
            first         <= 1'b1;
            min_w         <= '0;
            tready        <= 1'b0;
            result_valid  <= 1'b0;
            result_weight <= '0;
            total         <= '0;
`ifdef MIN_WEIGHT_ARGMIN_EN
            min_x           <= '0;
            result_solution <= '0;
`endif
        end else begin
            total <= total_nxt;
            if (state == COLLECT) begin
                tready <= 1'b1;
                if (accept) begin
                    if (tlast) begin
                        result_weight <= fold_w;
                        result_valid  <= 1'b1;
                        tready        <= 1'b0;
                        first         <= 1'b1;
                        state         <= RESULT;
`ifdef MIN_WEIGHT_ARGMIN_EN
                        result_solution <= fold_x;
`endif
                    end else begin
                        min_w <= fold_w;
                        first <= 1'b0;
`ifdef MIN_WEIGHT_ARGMIN_EN
                        min_x <= fold_x;
`endif
                    end
                end
            end else begin
                if (handshake) begin
                    result_valid <= 1'b0;
                    tready       <= 1'b1;
                    state        <= COLLECT;
                end
            end
        end
    end

endmodule

// File: tb/tb_min_weight_select.sv
// Testbench for min_weight_select: directed packets, a packet-level model
// checked every cycle, and literal expectations at key points. A second
// instance with a 3-bit total exercises saturation.
module tb_min_weight_select;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tvalid = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       tlast = 1'b0;
    logic       tready;
    logic [7:0] count_mask = 8'h00;
    logic       result_valid;
    logic       result_ready = 1'b1;
    logic [3:0] result_weight;
    logic       clear_total = 1'b0;
    logic [31:0] total;

    logic       tready3;
    logic       result_valid3;
    logic [3:0] result_weight3;
    logic [2:0] total3;
`ifdef MIN_WEIGHT_ARGMIN_EN
    logic [7:0] result_solution;
    logic [7:0] result_solution3;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    min_weight_select #(.DATA_WIDTH(8), .TOTAL_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .tvalid(tvalid), .tdata(tdata), .tlast(tlast),
        .tready(tready), .count_mask(count_mask), .result_valid(result_valid),
        .result_ready(result_ready), .result_weight(result_weight),
`ifdef MIN_WEIGHT_ARGMIN_EN
        .result_solution(result_solution),
`endif
        .clear_total(clear_total), .total(total)
    );

    min_weight_select #(.DATA_WIDTH(8), .TOTAL_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .tvalid(tvalid), .tdata(tdata), .tlast(tlast),
        .tready(tready3), .count_mask(count_mask), .result_valid(result_valid3),
        .result_ready(result_ready), .result_weight(result_weight3),
`ifdef MIN_WEIGHT_ARGMIN_EN
        .result_solution(result_solution3),
`endif
        .clear_total(clear_total), .total(total3)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: remember every accepted beat, pick the minimum at tlast.
    int          q_w[$];
    logic [7:0]  q_d[$];
    bit          m_valid = 1'b0;
    bit          m_tready = 1'b0;
    int          m_weight = 0;
    logic [7:0]  m_sol = 8'h00;
    longint      m_total = 0;
    longint      m_total3 = 0;
    bit          started = 1'b0;

    function automatic longint sat_add(input longint base, input longint add, input longint maxv);
        return (base + add > maxv) ? maxv : base + add;
    endfunction

    always @(posedge clk) begin
        longint base;
        longint base3;
        int     bi;
        started <= 1'b1;
        if (!rst_n) begin
            q_w.delete();
            q_d.delete();
            m_valid  = 1'b0;
            m_tready = 1'b0;
            m_weight = 0;
            m_sol    = 8'h00;
            m_total  = 0;
            m_total3 = 0;
        end else begin
            base  = clear_total ? 0 : m_total;
            base3 = clear_total ? 0 : m_total3;
            if (m_valid && result_ready) begin
                m_total  = sat_add(base, m_weight, 64'hFFFF_FFFF);
                m_total3 = sat_add(base3, m_weight, 7);
                m_valid  = 1'b0;
            end else begin
                m_total  = base;
                m_total3 = base3;
                if (!m_valid && m_tready && tvalid) begin
                    q_w.push_back($countones(tdata & count_mask));
                    q_d.push_back(tdata);
                    if (tlast) begin
                        bi = 0;
                        for (int i = 1; i < q_w.size(); i++) begin
                            if (q_w[i] < q_w[bi]) bi = i;
                        end
                        m_weight = q_w[bi];
                        m_sol    = q_d[bi];
                        m_valid  = 1'b1;
                        q_w.delete();
                        q_d.delete();
                    end
                end
            end
            m_tready = !m_valid;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("tready", tready, m_tready);
            chk("result_valid", result_valid, m_valid);
            chk("result_weight", result_weight, m_weight);
            chk("total", total, m_total);
            chk("tready3", tready3, m_tready);
            chk("result_valid3", result_valid3, m_valid);
            chk("result_weight3", result_weight3, m_weight);
            chk("total3", total3, m_total3);
`ifdef MIN_WEIGHT_ARGMIN_EN
            if (m_valid) begin
                chk("result_solution", result_solution, m_sol);
                chk("result_solution3", result_solution3, m_sol);
            end
`endif
        end
    end

    // Present one beat and wait (bounded) until it is accepted. Called at posedge+#1.
    task automatic send_beat(input logic [7:0] d, input logic last);
        bit r;
        bit done;
        done   = 1'b0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            r = tready;
            @(posedge clk);
            #1;
            if (r) done = 1'b1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        if (!done) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (3) step();
        chk("reset_tready", tready, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_weight", result_weight, 0);
        chk("reset_total", total, 0);
        rst_n = 1'b1;
        step();
        chk("tready_after_reset", tready, 1);

        // Basic packet: weights 3,1,2 -> 1 (8'h40)
        count_mask = 8'hE0;
        send_beat(8'hE0, 1'b0);
        send_beat(8'h40, 1'b0);
        send_beat(8'hA0, 1'b1);
        chk("basic_valid", result_valid, 1);
        chk("basic_weight", result_weight, 1);
        chk("basic_model_sol", m_sol, 8'h40);
`ifdef MIN_WEIGHT_ARGMIN_EN
        chk("basic_solution", result_solution, 8'h40);
`endif
        chk("basic_tready_stall", tready, 0);
        step();
        chk("basic_total", total, 1);
        chk("basic_valid_drop", result_valid, 0);

        // Tie: first beat wins
        count_mask = 8'hC0;
        send_beat(8'h80, 1'b0);
        send_beat(8'h40, 1'b1);
        chk("tie_weight", result_weight, 1);
        chk("tie_model_sol", m_sol, 8'h80);
`ifdef MIN_WEIGHT_ARGMIN_EN
        chk("tie_solution", result_solution, 8'h80);
`endif
        step();
        chk("tie_total", total, 2);

        // Back-pressure for 5 cycles
        count_mask = 8'hFF;
        result_ready = 1'b0;
        send_beat(8'h03, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_tready", tready, 0);
            chk("bp_valid", result_valid, 1);
            chk("bp_weight", result_weight, 2);
            chk("bp_total_hold", total, 2);
        end
        result_ready = 1'b1;
        step();
        chk("bp_total_once", total, 4);
        step();
        chk("bp_total_stays", total, 4);

        // Clear alone, then weights 2,0,3 and a coincident clear with weight 1
        clear_total = 1'b1;
        step();
        clear_total = 1'b0;
        chk("clear_alone", total, 0);
        send_beat(8'h0F, 1'b0);
        send_beat(8'h03, 1'b1);
        step();
        chk("run_total_a", total, 2);
        send_beat(8'h01, 1'b0);
        send_beat(8'h00, 1'b1);
        chk("run_weight_b", result_weight, 0);
        step();
        chk("run_total_b", total, 2);
        send_beat(8'h07, 1'b1);
        step();
        chk("run_total_c", total, 5);
        result_ready = 1'b0;
        send_beat(8'h01, 1'b1);
        clear_total  = 1'b1;
        result_ready = 1'b1;
        step();
        clear_total = 1'b0;
        chk("coincident_clear", total, 1);

        // Saturation on the 3-bit total instance
        clear_total = 1'b1;
        step();
        clear_total = 1'b0;
        send_beat(8'hF0, 1'b1);
        step();
        chk("sat_total3_a", total3, 4);
        chk("sat_total_a", total, 4);
        send_beat(8'h1F, 1'b1);
        step();
        chk("sat_total3_b", total3, 7);
        chk("sat_total_b", total, 9);
        send_beat(8'h01, 1'b1);
        step();
        chk("sat_total3_stick", total3, 7);

        // Reset mid-packet discards the partial minimum
        send_beat(8'h00, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midreset_total", total, 0);
        count_mask = 8'hF0;
        send_beat(8'hF0, 1'b1);
        chk("midreset_weight", result_weight, 4);
        chk("midreset_model_sol", m_sol, 8'hF0);
        step();
        chk("midreset_total_after", total, 4);
        chk("midreset_total3_after", total3, 4);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
